// File: rtl/cdr_pkg.sv
// Shared definitions for the CDR PI loop filter: FSM encoding and
// width-generic saturation / magnitude helpers.
package cdr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACQ  = 2'b01,
        ST_TRK  = 2'b10,
        ST_HOLD = 2'b11
    } cdr_state_e;

    // Clip a sign-extended value into the signed range of a w-bit word (w <= 63).
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                      input int unsigned         w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

    function automatic logic [63:0] abs_val(input logic signed [63:0] x);
        return (x < 0) ? $unsigned(-x) : $unsigned(x);
    endfunction

endpackage

// File: rtl/cdr_lock_detect.sv
// Lock detector: classifies each loop strobe as quiet/loud and counts runs,
// pulsing lock_hit (in ACQ) or unlock_hit (in TRK) when a run completes.
module cdr_lock_detect
    import cdr_pkg::*;
#(
    parameter int PD_W       = 16,
    parameter int LOCK_THR   = 32,
    parameter int LOCK_CNT   = 64,
    parameter int UNLOCK_CNT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   strobe,
    input  logic                   trk,
    input  logic                   clear,
    input  logic signed [PD_W-1:0] f_n,
    output logic                   lock_hit,
    output logic                   unlock_hit
);

    localparam int QW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(UNLOCK_CNT + 1);
    localparam logic [QW-1:0] Q_TERM = QW'(LOCK_CNT);
    localparam logic [LW-1:0] L_TERM = LW'(UNLOCK_CNT);
    localparam logic [PD_W:0] THR    = (PD_W + 1)'(LOCK_THR);

    logic [PD_W:0]   mag;
    logic            quiet;
    logic [QW-1:0]   quiet_cnt;
    logic [QW-1:0]   quiet_inc;
    logic [LW-1:0]   loud_cnt;
    logic [LW-1:0]   loud_inc;

    // One extra bit keeps |-2^(PD_W-1)| from wrapping back into the quiet band.
    assign mag   = (PD_W + 1)'(abs_val(64'(f_n)));
    assign quiet = (mag <= THR);

    assign quiet_inc = (quiet_cnt == Q_TERM) ? Q_TERM : quiet_cnt + 1'b1;
    assign loud_inc  = (loud_cnt  == L_TERM) ? L_TERM : loud_cnt  + 1'b1;

    assign lock_hit   = strobe && !trk &&  quiet && (quiet_inc == Q_TERM);
    assign unlock_hit = strobe &&  trk && !quiet && (loud_inc  == L_TERM);

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quiet_cnt <= '0;
            loud_cnt  <= '0;
        end else if (clear || lock_hit || unlock_hit) begin
            quiet_cnt <= '0;
            loud_cnt  <= '0;
        end else if (strobe) begin
            if (trk) begin
                loud_cnt  <= quiet ? '0 : loud_inc;
                quiet_cnt <= '0;
            end else begin
                quiet_cnt <= quiet ? quiet_inc : '0;
                loud_cnt  <= '0;
            end
        end
    end

endmodule

// File: rtl/cdr_pi_gearshift.sv
// CDR PI loop filter with ACQ/TRK gain gear-shift, saturating integrator and
// output, freeze hold-over and lock detection; all updates qualified by en.
module cdr_pi_gearshift
    import cdr_pkg::*;
#(
    parameter int PD_W       = 16,
    parameter int ACC_W      = 32,
    parameter int KP_ACQ     = 4,
    parameter int KI_ACQ     = 10,
    parameter int KP_TRK     = 6,
    parameter int KI_TRK     = 12,
    parameter int DFCW_SHIFT = 18,
    parameter int LOCK_THR   = 32,
    parameter int LOCK_CNT   = 64,
    parameter int UNLOCK_CNT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [PD_W-1:0]  f_n,
    input  logic                    freeze,
    input  logic                    relock,
    output logic signed [ACC_W-1:0] v_ctrl,
    output logic signed [ACC_W-1:0] dfcw,
    output logic                    locked,
    output logic [1:0]              state,
    output logic                    sat
);

    cdr_state_e state_q, state_nxt;
    cdr_state_e saved_q, saved_nxt;

    logic signed [ACC_W-1:0] sum_f;
    logic                    upd;
    logic                    in_trk;
    logic                    lock_hit;
    logic                    unlock_hit;

    logic signed [ACC_W-1:0] f_ext;
    logic signed [ACC_W-1:0] p_term;
    logic signed [ACC_W-1:0] i_term;
    logic signed [ACC_W+1:0] sum_wide;
    logic signed [ACC_W+1:0] v_wide;
    logic signed [63:0]      sum_sat;
    logic signed [63:0]      v_sat;
    logic                    clip;

    assign in_trk = (state_q == ST_TRK);
    assign upd    = en && !freeze && !relock && (state_q != ST_HOLD);

    cdr_lock_detect #(
        .PD_W       (PD_W),
        .LOCK_THR   (LOCK_THR),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) u_lock (
        .clk        (clk),
        .rst        (rst),
        .strobe     (upd),
        .trk        (in_trk),
        .clear      (relock),
        .f_n        (f_n),
        .lock_hit   (lock_hit),
        .unlock_hit (unlock_hit)
    );

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state_q;
        saved_nxt = saved_q;
        if (freeze) begin
            state_nxt = ST_HOLD;
            if (relock || state_q == ST_IDLE || state_q == ST_ACQ)
                saved_nxt = ST_ACQ;
            else if (state_q == ST_TRK)
                saved_nxt = ST_TRK;
        end else if (relock) begin
            state_nxt = ST_ACQ;
        end else if (state_q == ST_HOLD) begin
            state_nxt = saved_q;
        end else if (upd) begin
            if (in_trk)
                state_nxt = unlock_hit ? ST_ACQ : ST_TRK;
            else
                state_nxt = lock_hit ? ST_TRK : ST_ACQ;
        end
    end

    // Gains follow the state before the edge; IDLE uses acquisition gains.
    assign f_ext  = ACC_W'(f_n);
    assign p_term = in_trk ? (f_ext >>> KP_TRK) : (f_ext >>> KP_ACQ);
    assign i_term = in_trk ? (sum_f >>> KI_TRK) : (sum_f >>> KI_ACQ);

    assign sum_wide = (ACC_W + 2)'(sum_f) + (ACC_W + 2)'(f_n);
    assign v_wide   = (ACC_W + 2)'(v_ctrl) + (ACC_W + 2)'(p_term) + (ACC_W + 2)'(i_term);
    assign sum_sat  = sat_signed(64'(sum_wide), ACC_W);
    assign v_sat    = sat_signed(64'(v_wide), ACC_W);
    assign clip     = (sum_sat != 64'(sum_wide)) || (v_sat != 64'(v_wide));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            saved_q <= ST_ACQ;
            locked  <= 1'b0;
            sum_f   <= '0;
            v_ctrl  <= '0;
            sat     <= 1'b0;
        end else begin
            state_q <= state_nxt;
            saved_q <= saved_nxt;
            locked  <= (state_nxt == ST_TRK);
            if (upd) begin
                sum_f  <= ACC_W'(sum_sat);
                v_ctrl <= ACC_W'(v_sat);
            end
            if (relock)
                sat <= 1'b0;
            else if (upd && clip)
                sat <= 1'b1;
        end
    end

    assign dfcw  = v_ctrl >>> DFCW_SHIFT;
    assign state = state_q;

endmodule

// File: tb/tb_cdr_pi_gearshift.sv
// Directed self-checking bench for cdr_pi_gearshift: reset, arithmetic,
// lock/unlock, freeze hold-over and output saturation.
module tb_cdr_pi_gearshift;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic signed [15:0] f_n = '0;
    logic               freeze = 1'b0;
    logic               relock = 1'b0;
    logic signed [31:0] v_ctrl;
    logic signed [31:0] dfcw;
    logic               locked;
    logic [1:0]         state;
    logic               sat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cdr_pi_gearshift dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .f_n    (f_n),
        .freeze (freeze),
        .relock (relock),
        .v_ctrl (v_ctrl),
        .dfcw   (dfcw),
        .locked (locked),
        .state  (state),
        .sat    (sat)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Holds en high for n consecutive clocks; returns on the negedge after the last strobe.
    task automatic burst(input int n, input logic signed [15:0] f);
        @(negedge clk);
        en  = 1'b1;
        f_n = f;
        repeat (n) @(negedge clk);
        en  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_v",      64'(v_ctrl), 64'd0);
        check("rst_dfcw",   64'(dfcw),   64'd0);
        check("rst_state",  64'(state),  64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_sat",    64'(sat),    64'd0);

        // Arithmetic from zero state: p = 1024>>>4, then i = 1024>>>10
        burst(1, 16'sd1024);
        check("arith_v1",    64'(v_ctrl),    64'(32'sd64));
        check("arith_state", 64'(state),     64'd1);
        check("arith_sum",   64'(dut.sum_f), 64'(32'sd1024));
        burst(1, 16'sd0);
        check("arith_v2",    64'(v_ctrl), 64'(32'sd65));
        check("arith_dfcw",  64'(dfcw),   64'd0);

        // Asynchronous reset mid-cycle with en active
        @(negedge clk);
        en  = 1'b1;
        f_n = 16'sd1000;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_v",      64'(v_ctrl), 64'd0);
        check("mid_rst_dfcw",   64'(dfcw),   64'd0);
        check("mid_rst_state",  64'(state),  64'd0);
        check("mid_rst_locked", 64'(locked), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;

        // Lock: 64 quiet strobes, the first from IDLE
        burst(63, 16'sd5);
        check("lock63_state",  64'(state),  64'd1);
        check("lock63_locked", 64'(locked), 64'd0);
        burst(1, 16'sd5);
        check("lock64_state",  64'(state),  64'd2);
        check("lock64_locked", 64'(locked), 64'd1);
        check("lock64_v",      64'(v_ctrl), 64'd0);
        // Tracking gains: p = 1024>>>6 = 16, i = 320>>>12 = 0
        burst(1, 16'sd1024);
        check("trk_gain_v",     64'(v_ctrl), 64'(32'sd16));
        check("trk_gain_state", 64'(state),  64'd2);

        // Freeze in TRK: strobes ignored, state HOLD
        @(negedge clk);
        freeze = 1'b1;
        burst(3, 16'sd500);
        check("frz_state",  64'(state),  64'd3);
        check("frz_v",      64'(v_ctrl), 64'(32'sd16));
        check("frz_locked", 64'(locked), 64'd0);
        @(negedge clk);
        freeze = 1'b0;
        en     = 1'b1;
        f_n    = 16'sd500;
        @(negedge clk);
        en     = 1'b0;
        check("unfrz_state",  64'(state),  64'd2);
        check("unfrz_v",      64'(v_ctrl), 64'(32'sd16));
        check("unfrz_locked", 64'(locked), 64'd1);

        // Unlock: a quiet strobe breaks the loud run
        burst(1, 16'sd0);
        check("unl_q_v", 64'(v_ctrl), 64'(32'sd16));
        burst(15, 16'sd100);
        check("unl15_v",     64'(v_ctrl), 64'(32'sd31));
        check("unl15_state", 64'(state),  64'd2);
        burst(1, 16'sd0);
        check("unl_break_state", 64'(state),  64'd2);
        check("unl_break_v",     64'(v_ctrl), 64'(32'sd31));
        burst(15, -16'sd32768);
        check("unl_neg15_state",  64'(state),  64'd2);
        check("unl_neg15_locked", 64'(locked), 64'd1);
        burst(1, -16'sd32768);
        check("unl_neg16_state",  64'(state),  64'd1);
        check("unl_neg16_locked", 64'(locked), 64'd0);
        check("unl_neg16_v",      64'(v_ctrl), 64'(-32'sd9121));
        check("unl_neg16_dfcw",   64'(dfcw),   64'(-32'sd1));
        check("unl_sat",          64'(sat),    64'd0);

        // Saturation of v_ctrl under a sustained full-scale error
        do_reset();
        burst(12500, 16'sd32767);
        check("sat_v",     64'(v_ctrl), 64'(32'sh7FFF_FFFF));
        check("sat_flag",  64'(sat),    64'd1);
        check("sat_state", 64'(state),  64'd1);
        burst(1, 16'sd32767);
        check("sat_nowrap_v", 64'(v_ctrl), 64'(32'sh7FFF_FFFF));
        @(negedge clk);
        relock = 1'b1;
        @(negedge clk);
        relock = 1'b0;
        check("relock_sat",   64'(sat),    64'd0);
        check("relock_v",     64'(v_ctrl), 64'(32'sh7FFF_FFFF));
        check("relock_state", 64'(state),  64'd1);
        check("relock_dfcw",  64'(dfcw),   64'(32'sd8191));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
